// File: rtl/tb_uart_transceiver.sv
// Full-duplex 8N1 UART peer for the chip's UART pins: serialises tx_data onto ser_tx, deserialises ser_rx.
// Optional macro TB_UART_PARITY_EN adds an even-parity bit in both directions and the rx_parity_err output.
module tb_uart_transceiver #(
    parameter int unsigned CLKS_PER_BIT = 4167
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ser_rx,
    output logic       ser_tx,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_clear_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
`ifdef TB_UART_PARITY_EN
    ,
    output logic       rx_parity_err
`endif
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Transmit side
    // ------------------------------------------------------------------
    tx_state_t        r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift;
    logic             r_tx_start_d;
`ifdef TB_UART_PARITY_EN
    logic             r_tx_par;
`endif
    logic             w_tx_edge;

    assign w_tx_edge = tx_start & ~r_tx_start_d;

    // Only a fresh rising edge seen in IDLE launches a frame; DONE waits for tx_start to drop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_state   <= TX_IDLE;
            r_tx_cnt     <= '0;
            r_tx_bit     <= '0;
            r_tx_shift   <= '0;
            r_tx_start_d <= 1'b0;
`ifdef TB_UART_PARITY_EN
            r_tx_par     <= 1'b0;
`endif
            ser_tx       <= 1'b1;
            tx_busy      <= 1'b0;
            tx_clear_req <= 1'b0;
        end else begin
            r_tx_start_d <= tx_start;
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_edge) begin
                        r_tx_shift <= tx_data;
`ifdef TB_UART_PARITY_EN
                        r_tx_par   <= ^tx_data;
`endif
                        r_tx_cnt   <= '0;
                        tx_busy    <= 1'b1;
                        ser_tx     <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        ser_tx     <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
`ifdef TB_UART_PARITY_EN
                            ser_tx     <= r_tx_par;
                            r_tx_state <= TX_PARITY;
`else
                            ser_tx     <= 1'b1;
                            r_tx_state <= TX_STOP;
`endif
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            ser_tx     <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
`ifdef TB_UART_PARITY_EN
                TX_PARITY: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        ser_tx     <= 1'b1;
                        r_tx_state <= TX_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
`endif
                TX_STOP: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt     <= '0;
                        tx_busy      <= 1'b0;
                        tx_clear_req <= 1'b1;
                        r_tx_state   <= TX_DONE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
                TX_DONE: begin
                    if (!tx_start) begin
                        tx_clear_req <= 1'b0;
                        r_tx_state   <= TX_IDLE;
                    end
                end
                default: begin
                    ser_tx     <= 1'b1;
                    tx_busy    <= 1'b0;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive side
    // ------------------------------------------------------------------
    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
`ifdef TB_UART_PARITY_EN
    logic             r_rx_par_ok;
`endif
    logic             w_rx_fall;

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // Start detection uses the synchronised line; all later samples land at bit centres.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
`ifdef TB_UART_PARITY_EN
            r_rx_par_ok   <= 1'b1;
            rx_parity_err <= 1'b0;
`endif
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            r_rx_meta    <= ser_rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef TB_UART_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
`ifdef TB_UART_PARITY_EN
                            r_rx_state <= RX_PARITY;
`else
                            r_rx_state <= RX_STOP;
`endif
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
`ifdef TB_UART_PARITY_EN
                RX_PARITY: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt    <= '0;
                        r_rx_par_ok <= ((^r_rx_shift) == r_rx_sync);
                        r_rx_state  <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
`endif
                RX_STOP: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (!r_rx_sync) begin
                            rx_frame_err <= 1'b1;
                        end
`ifdef TB_UART_PARITY_EN
                        if (!r_rx_par_ok) begin
                            rx_parity_err <= 1'b1;
                        end else if (r_rx_sync) begin
                            rx_data  <= r_rx_shift;
                            rx_valid <= 1'b1;
                        end
`else
                        if (r_rx_sync) begin
                            rx_data  <= r_rx_shift;
                            rx_valid <= 1'b1;
                        end
`endif
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tb_uart_transceiver.sv
// Self-checking bench for tb_uart_transceiver: TX frames against a bit-list model, RX bytes via a pulse monitor.
// Build with TB_UART_PARITY_EN to cover the parity variant.
module tb_tb_uart_transceiver;

    localparam int CPB = 16;
`ifdef TB_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int RX_LAT = 2 + CPB * (NBITS - 1) + CPB / 2;

    logic       clock;
    logic       reset;
    logic       ser_rx;
    logic       ser_tx;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_clear_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
`ifdef TB_UART_PARITY_EN
    logic       rx_parity_err;
`endif

    tb_uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .ser_rx       (ser_rx),
        .ser_tx       (ser_tx),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .tx_clear_req (tx_clear_req),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
`ifdef TB_UART_PARITY_EN
        ,
        .rx_parity_err(rx_parity_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] q_rx_data[$];
    int         q_rx_cyc[$];
    int         n_ferr = 0;
    int         n_perr = 0;
    logic [7:0] last_rx = 8'h00;
    int         rx_c0;
    int         rx_c1;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Receive-side monitor: records every strobe with the cycle it was seen.
    always @(negedge clock) begin
        if (!reset) begin
            if (rx_valid) begin
                q_rx_data.push_back(rx_data);
                q_rx_cyc.push_back(cyc);
            end
            if (rx_frame_err) n_ferr = n_ferr + 1;
`ifdef TB_UART_PARITY_EN
            if (rx_parity_err) n_perr = n_perr + 1;
`endif
        end
    end

    // Line level of bit idx within a frame carrying byte d.
    function automatic logic frame_bit(input logic [7:0] d, input int idx, input logic par, input logic stop);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9 && NBITS == 11) return par;
        return stop;
    endfunction

    task automatic clear_monitor();
        q_rx_data.delete();
        q_rx_cyc.delete();
        n_ferr = 0;
        n_perr = 0;
    endtask

    task automatic send_and_check(input logic [7:0] d, input string name);
        int bad_line;
        int bad_busy;
        bad_line = 0;
        bad_busy = 0;
        tx_start = 1'b0;
        @(negedge clock);
        tx_data  = d;
        tx_start = 1'b1;
        for (int k = 0; k < NBITS * CPB; k++) begin
            @(negedge clock);
            if (k == 0) tx_data = 8'($urandom);
            n_checks++;
            if (ser_tx !== frame_bit(d, k / CPB, ^d, 1'b1)) begin
                n_fail++;
                if (bad_line == 0)
                    $display("FAIL %s ser_tx cycle %0d: got %b expected %b", name, k, ser_tx,
                             frame_bit(d, k / CPB, ^d, 1'b1));
                bad_line++;
            end
            n_checks++;
            if (tx_busy !== 1'b1) begin
                n_fail++;
                if (bad_busy == 0) $display("FAIL %s tx_busy cycle %0d: got %b expected 1", name, k, tx_busy);
                bad_busy++;
            end
        end
        @(negedge clock);
        n_checks++;
        if (tx_busy !== 1'b0 || tx_clear_req !== 1'b1 || ser_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done: busy=%b clear_req=%b ser_tx=%b expected 0 1 1", name, tx_busy, tx_clear_req, ser_tx);
        end
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic par, input logic stop, output int c0);
        @(negedge clock);
        c0 = cyc;
        for (int i = 0; i < NBITS; i++) begin
            ser_rx = frame_bit(d, i, par, stop);
            repeat (CPB) @(negedge clock);
        end
        ser_rx = 1'b1;
    endtask

    task automatic check_rx_one(input logic [7:0] d, input int c0, input string name);
        n_checks++;
        if (q_rx_data.size() != 1) begin
            n_fail++;
            $display("FAIL %s rx_valid count: got %0d expected 1", name, q_rx_data.size());
        end else begin
            n_checks++;
            if (q_rx_data[0] !== d) begin
                n_fail++;
                $display("FAIL %s rx_data: got %h expected %h", name, q_rx_data[0], d);
            end
            n_checks++;
            if (q_rx_cyc[0] - c0 < RX_LAT - 1 || q_rx_cyc[0] - c0 > RX_LAT + 1) begin
                n_fail++;
                $display("FAIL %s rx latency: got %0d expected %0d+-1", name, q_rx_cyc[0] - c0, RX_LAT);
            end
            last_rx = d;
        end
        n_checks++;
        if (n_ferr != 0 || n_perr != 0) begin
            n_fail++;
            $display("FAIL %s error strobes: frame %0d parity %0d expected 0 0", name, n_ferr, n_perr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ser_rx = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
        repeat (4) @(negedge clock);
        n_checks++;
        if (ser_tx !== 1'b1 || tx_busy !== 1'b0 || tx_clear_req !== 1'b0 ||
            rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: ser_tx=%b busy=%b clr=%b rx_data=%h valid=%b ferr=%b expected 1 0 0 00 0 0",
                     ser_tx, tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err);
        end
`ifdef TB_UART_PARITY_EN
        n_checks++;
        if (rx_parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset rx_parity_err: got %b expected 0", rx_parity_err);
        end
`endif
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_tx_byte();
        send_and_check(8'h3D, "tx_3d");
    endtask

    task automatic test_tx_held();
        int bad;
        bad = 0;
        send_and_check(8'h0A, "tx_0a");
        for (int k = 0; k < 3 * CPB; k++) begin
            @(negedge clock);
            n_checks++;
            if (ser_tx !== 1'b1 || tx_clear_req !== 1'b1 || tx_busy !== 1'b0) begin
                n_fail++;
                if (bad == 0)
                    $display("FAIL held_start cycle %0d: ser_tx=%b clr=%b busy=%b expected 1 1 0", k, ser_tx, tx_clear_req, tx_busy);
                bad++;
            end
        end
        tx_start = 1'b0;
        @(negedge clock);
        n_checks++;
        if (tx_clear_req !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_req drop: got %b expected 0", tx_clear_req);
        end
        send_and_check(8'h0F, "tx_0f");
    endtask

    task automatic test_rx_byte();
        clear_monitor();
        drive_rx_frame(8'h3E, ^8'h3E, 1'b1, rx_c0);
        repeat (CPB) @(negedge clock);
        check_rx_one(8'h3E, rx_c0, "rx_3e");
    endtask

    task automatic test_rx_glitch_framing();
        clear_monitor();
        @(negedge clock);
        ser_rx = 1'b0;
        repeat (CPB / 4) @(negedge clock);
        ser_rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        n_checks++;
        if (q_rx_data.size() != 0 || n_ferr != 0) begin
            n_fail++;
            $display("FAIL glitch: valid %0d frame_err %0d expected 0 0", q_rx_data.size(), n_ferr);
        end
        drive_rx_frame(8'h44, ^8'h44, 1'b0, rx_c0);
        repeat (CPB) @(negedge clock);
        n_checks++;
        if (n_ferr != 1) begin
            n_fail++;
            $display("FAIL framing rx_frame_err count: got %0d expected 1", n_ferr);
        end
        n_checks++;
        if (q_rx_data.size() != 0) begin
            n_fail++;
            $display("FAIL framing rx_valid count: got %0d expected 0", q_rx_data.size());
        end
        n_checks++;
        if (rx_data !== last_rx) begin
            n_fail++;
            $display("FAIL framing rx_data: got %h expected %h", rx_data, last_rx);
        end
    endtask

    task automatic test_full_duplex(input logic [7:0] dt, input logic [7:0] dr, input string name);
        clear_monitor();
        fork
            send_and_check(dt, name);
            drive_rx_frame(dr, ^dr, 1'b1, rx_c0);
        join
        repeat (CPB) @(negedge clock);
        check_rx_one(dr, rx_c0, name);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom);
        b = 8'($urandom);
        clear_monitor();
        drive_rx_frame(a, ^a, 1'b1, rx_c0);
        drive_rx_frame(b, ^b, 1'b1, rx_c1);
        repeat (CPB) @(negedge clock);
        n_checks++;
        if (q_rx_data.size() != 2) begin
            n_fail++;
            $display("FAIL back_to_back count: got %0d expected 2", q_rx_data.size());
        end else begin
            n_checks++;
            if (q_rx_data[0] !== a || q_rx_data[1] !== b) begin
                n_fail++;
                $display("FAIL back_to_back data: got %h %h expected %h %h", q_rx_data[0], q_rx_data[1], a, b);
            end
            n_checks++;
            if (q_rx_cyc[1] - rx_c1 < RX_LAT - 1 || q_rx_cyc[1] - rx_c1 > RX_LAT + 1) begin
                n_fail++;
                $display("FAIL back_to_back latency: got %0d expected %0d+-1", q_rx_cyc[1] - rx_c1, RX_LAT);
            end
            last_rx = b;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            test_full_duplex(8'($urandom), 8'($urandom), "random");
        end
    endtask

`ifdef TB_UART_PARITY_EN
    task automatic test_parity();
        send_and_check(8'h3D, "parity_tx_3d");
        clear_monitor();
        drive_rx_frame(8'h3D, 1'b0, 1'b1, rx_c0);
        repeat (CPB) @(negedge clock);
        n_checks++;
        if (n_perr != 1) begin
            n_fail++;
            $display("FAIL parity rx_parity_err count: got %0d expected 1", n_perr);
        end
        n_checks++;
        if (q_rx_data.size() != 0 || rx_data !== last_rx) begin
            n_fail++;
            $display("FAIL parity suppression: valid %0d rx_data %h expected 0 %h", q_rx_data.size(), rx_data, last_rx);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        tx_start = 1'b0;
        @(negedge clock);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        repeat (3 * CPB + 5) @(negedge clock);
        n_checks++;
        if (tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame busy before reset: got %b expected 1", tx_busy);
        end
        reset    = 1'b1;
        tx_start = 1'b0;
        @(negedge clock);
        n_checks++;
        if (ser_tx !== 1'b1 || tx_busy !== 1'b0 || tx_clear_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_frame reset: ser_tx=%b busy=%b clr=%b expected 1 0 0", ser_tx, tx_busy, tx_clear_req);
        end
        @(negedge clock);
        reset = 1'b0;
        last_rx = 8'h00;
        repeat (2) @(negedge clock);
        send_and_check(8'($urandom), "after_reset");
    endtask

    initial begin
        test_reset();
        test_tx_byte();
        test_tx_held();
        test_rx_byte();
        test_rx_glitch_framing();
        test_full_duplex(8'h0A, 8'h50, "duplex_0a_50");
        test_back_to_back();
        test_random();
`ifdef TB_UART_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
